prach_deframer: RTL and testbench

PRACH_DEFRAMER -- requirements
Module: prach_deframer

---
 rtl/prach_deframer.sv | 222 ++++++++++++++++++++++
 tb/tb_prach_deframer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prach_deframer.sv
// prach_deframer: unpacks 128-bit U-plane beats (4 IQ samples) into one sample per clk_dsp, 2 cycles SOP-to-sample.
// Registered ready throttles the source to the 2-beat FIFO; define PRACH_DEFRAMER_STATS_EN to build pkt_cnt/err_cnt.
module prach_deframer #(
   parameter int         NUM_SAMPLES      = 839,
   parameter logic [3:0] EXP_FILTER_INDEX = 4'd1
) (
   input  logic         clk_dsp,
   input  logic         rst_dsp,
   input  logic [127:0] avst_sink_u_data,
   input  logic         avst_sink_u_valid,
   input  logic         avst_sink_u_startofpacket,
   input  logic         avst_sink_u_endofpacket,
   output logic         avst_sink_u_ready,
   input  logic         rx_u_dataDirection,
   input  logic [3:0]   rx_u_filterIndex,
   input  logic [15:0]  rx_u_pc_id,
   output logic [15:0]  dout_dr,
   output logic [15:0]  dout_di,
   output logic         dout_dv,
   output logic [7:0]   dout_chn,
   output logic         sync_out,
   output logic         dout_last,
   output logic         err,
   output logic [15:0]  pkt_cnt,
   output logic [15:0]  err_cnt
);

   localparam int              NB   = (NUM_SAMPLES + 3) / 4;
   localparam int              BW   = $clog2(NB + 1);
   localparam logic [BW-1:0]   NB_V = BW'(NB);
   localparam logic [1:0]      LL_B = 2'((NUM_SAMPLES - 1) % 4);

   typedef enum logic [1:0] {IDLE, DATA, DROP} state_t;

   typedef struct packed {
      logic [127:0] dat;
      logic [7:0]   chn;
      logic         first;
      logic         last;
      logic [1:0]   last_lane;
   } entry_t;

   state_t        state, state_nxt;
   logic [BW-1:0] bcnt, bcnt_nxt, beat_n;
   logic [7:0]    chn_cur, chn_nxt;

   entry_t        fifo_mem [2];
   entry_t        head, push_ent;
   logic          wr_ptr, rd_ptr;
   logic [1:0]    fifo_cnt, fifo_cnt_nxt;
   logic [1:0]    lane;
   logic [31:0]   lane_dat;

   logic          acc, sop_ok, take_beat, push, pop, err_c, retro_last;
   logic          retro_tail, retro_s1, retro_out;

   logic          s1_vld, s1_first, s1_last;
   logic [15:0]   s1_dr, s1_di;
   logic [7:0]    s1_chn;

   logic          unused_pc_hi;
   assign unused_pc_hi = ^rx_u_pc_id[15:8];

   assign acc    = avst_sink_u_valid && avst_sink_u_ready;
   assign sop_ok = !rx_u_dataDirection && (rx_u_filterIndex == EXP_FILTER_INDEX);

   always_ff @(posedge clk_dsp) begin
      if (rst_dsp) begin
         state   <= IDLE;
         bcnt    <= '0;
         chn_cur <= '0;
      end else begin
         state   <= state_nxt;
         bcnt    <= bcnt_nxt;
         chn_cur <= chn_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      bcnt_nxt   = bcnt;
      chn_nxt    = chn_cur;
      beat_n     = bcnt + BW'(1);
      take_beat  = 1'b0;
      err_c      = 1'b0;
      retro_last = 1'b0;
      push_ent.dat       = avst_sink_u_data;
      push_ent.chn       = chn_cur;
      push_ent.first     = 1'b0;
      push_ent.last      = 1'b0;
      push_ent.last_lane = 2'd3;

      if (acc) begin
         if (state == DROP) begin
            if (avst_sink_u_endofpacket) state_nxt = IDLE;
         end else if (avst_sink_u_startofpacket) begin
            // A new SOP while a packet is open closes the old one on its last queued sample.
            if (state == DATA) begin
               err_c      = 1'b1;
               retro_last = 1'b1;
            end
            if (sop_ok) begin
               chn_nxt        = rx_u_pc_id[7:0];
               push_ent.chn   = rx_u_pc_id[7:0];
               push_ent.first = 1'b1;
               beat_n         = BW'(1);
               take_beat      = 1'b1;
            end else begin
               err_c     = 1'b1;
               state_nxt = avst_sink_u_endofpacket ? IDLE : DROP;
            end
         end else if (state == DATA) begin
            take_beat = 1'b1;
         end else begin
            err_c = 1'b1;
         end
      end

      if (take_beat) begin
         bcnt_nxt = beat_n;
         if (beat_n == NB_V) begin
            push_ent.last      = 1'b1;
            push_ent.last_lane = LL_B;
            if (avst_sink_u_endofpacket) begin
               state_nxt = IDLE;
            end else begin
               err_c     = 1'b1;
               state_nxt = DROP;
            end
         end else if (avst_sink_u_endofpacket) begin
            err_c         = 1'b1;
            push_ent.last = 1'b1;
            state_nxt     = IDLE;
         end else begin
            state_nxt = DATA;
         end
      end
   end

   assign push         = take_beat;
   assign head         = fifo_mem[rd_ptr];
   assign lane_dat     = head.dat[{lane, 5'd0} +: 32];
   assign pop          = (fifo_cnt != 2'd0) && (lane == head.last_lane);
   assign fifo_cnt_nxt = fifo_cnt + 2'(push) - 2'(pop);

   // The sample to re-flag lives in the FIFO tail, in stage 1, or is just leaving stage 1.
   assign retro_tail = retro_last && (fifo_cnt != 2'd0) && !((fifo_cnt == 2'd1) && pop);
   assign retro_s1   = retro_last && (fifo_cnt == 2'd1) && pop;
   assign retro_out  = retro_last && (fifo_cnt == 2'd0);

   always_ff @(posedge clk_dsp) begin
      if (push)       fifo_mem[wr_ptr]       <= push_ent;
      if (retro_tail) fifo_mem[~wr_ptr].last <= 1'b1;
   end

   always_ff @(posedge clk_dsp) begin
      if (rst_dsp) begin
         wr_ptr            <= 1'b0;
         rd_ptr            <= 1'b0;
         fifo_cnt          <= 2'd0;
         lane              <= 2'd0;
         avst_sink_u_ready <= 1'b0;
         s1_vld            <= 1'b0;
         s1_first          <= 1'b0;
         s1_last           <= 1'b0;
         s1_dr             <= '0;
         s1_di             <= '0;
         s1_chn            <= '0;
         dout_dv           <= 1'b0;
         dout_dr           <= '0;
         dout_di           <= '0;
         dout_chn          <= '0;
         sync_out          <= 1'b0;
         dout_last         <= 1'b0;
         err               <= 1'b0;
      end else begin
         fifo_cnt          <= fifo_cnt_nxt;
         avst_sink_u_ready <= (fifo_cnt_nxt < 2'd2) || (state_nxt == DROP);
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;

         s1_vld <= (fifo_cnt != 2'd0);
         if (fifo_cnt != 2'd0) begin
            s1_dr    <= lane_dat[15:0];
            s1_di    <= lane_dat[31:16];
            s1_chn   <= head.chn;
            s1_first <= head.first && (lane == 2'd0);
            s1_last  <= (head.last && pop) || retro_s1;
            lane     <= pop ? 2'd0 : lane + 2'd1;
         end

         dout_dv   <= s1_vld;
         sync_out  <= s1_vld && s1_first;
         dout_last <= s1_vld && (s1_last || retro_out);
         if (s1_vld) begin
            dout_dr  <= s1_dr;
            dout_di  <= s1_di;
            dout_chn <= s1_chn;
         end
         err <= err_c;
      end
   end

`ifdef PRACH_DEFRAMER_STATS_EN
   logic pkt_done;
   assign pkt_done = take_beat && (beat_n == NB_V) && avst_sink_u_endofpacket;

   always_ff @(posedge clk_dsp) begin
      if (rst_dsp) begin
         pkt_cnt <= '0;
         err_cnt <= '0;
      end else begin
         if (pkt_done && (pkt_cnt != 16'hFFFF)) pkt_cnt <= pkt_cnt + 16'd1;
         if (err_c && (err_cnt != 16'hFFFF))    err_cnt <= err_cnt + 16'd1;
      end
   end
`else
   assign pkt_cnt = '0;
   assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_prach_deframer.sv
// Directed bench for prach_deframer: packet-level sample model plus literal per-scenario expectations.
module tb_prach_deframer;

   localparam int NS = 839;
   localparam int NB = (NS + 3) / 4;

   logic         clk_dsp = 1'b0;
   logic         rst_dsp = 1'b1;
   logic [127:0] avst_sink_u_data = '0;
   logic         avst_sink_u_valid = 1'b0;
   logic         avst_sink_u_startofpacket = 1'b0;
   logic         avst_sink_u_endofpacket = 1'b0;
   logic         avst_sink_u_ready;
   logic         rx_u_dataDirection = 1'b0;
   logic [3:0]   rx_u_filterIndex = 4'd1;
   logic [15:0]  rx_u_pc_id = '0;
   logic [15:0]  dout_dr, dout_di;
   logic         dout_dv;
   logic [7:0]   dout_chn;
   logic         sync_out, dout_last, err;
   logic [15:0]  pkt_cnt, err_cnt;

   prach_deframer #(.NUM_SAMPLES(NS), .EXP_FILTER_INDEX(4'd1)) dut (
      .clk_dsp(clk_dsp), .rst_dsp(rst_dsp),
      .avst_sink_u_data(avst_sink_u_data), .avst_sink_u_valid(avst_sink_u_valid),
      .avst_sink_u_startofpacket(avst_sink_u_startofpacket),
      .avst_sink_u_endofpacket(avst_sink_u_endofpacket),
      .avst_sink_u_ready(avst_sink_u_ready),
      .rx_u_dataDirection(rx_u_dataDirection), .rx_u_filterIndex(rx_u_filterIndex),
      .rx_u_pc_id(rx_u_pc_id),
      .dout_dr(dout_dr), .dout_di(dout_di), .dout_dv(dout_dv), .dout_chn(dout_chn),
      .sync_out(sync_out), .dout_last(dout_last), .err(err),
      .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
   );

   always #5 clk_dsp = ~clk_dsp;

   typedef struct {
      logic [15:0] dr;
      logic [15:0] di;
      logic [7:0]  chn;
      logic        sync;
      logic        last;
   } exp_t;

   exp_t exp_q[$];
   exp_t e_cur;

   int tests = 0, fails = 0;
   int cyc = 0;
   int n_samp, n_err, n_last, n_gap, last_idx, exp_err, sync_cyc, sop_cyc;
   int acc_first, acc_last;
   logic [7:0] last_chn;
   bit in_pkt;

   always @(posedge clk_dsp) cyc++;

   function automatic logic [15:0] samp_dr(input logic [3:0] tag, input int s);
      logic [11:0] s12;
      s12 = 12'(s);
      return {tag, s12};
   endfunction

   task automatic check(input string name, input int act, input int expv);
      tests++;
      if (act != expv) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, expv);
      end
   endtask

   task automatic begin_scn();
      n_samp = 0; n_err = 0; n_last = 0; n_gap = 0; last_idx = -1;
      exp_err = 0; sync_cyc = -1; sop_cyc = -1; in_pkt = 0; last_chn = '0;
   endtask

   // Expected output of one packet, straight from the packet rules.
   task automatic model_pkt(input int nbeats, input int eop_beat, input logic [3:0] filt,
                            input logic [15:0] pc, input logic [3:0] tag);
      exp_t e;
      int   nl, last_s, s;
      bit   stop;
      if (filt != 4'd1) begin
         exp_err++;
         return;
      end
      for (int n = 1; n <= nbeats; n++) begin
         nl = 4; last_s = -1; stop = 0;
         if (n == NB) begin
            nl = NS - 4 * (NB - 1); last_s = NS - 1; stop = 1;
            if (eop_beat != n) exp_err++;
         end else if (n == eop_beat) begin
            last_s = 4 * n - 1; stop = 1; exp_err++;
         end
         for (int k = 0; k < nl; k++) begin
            s = 4 * (n - 1) + k;
            e.dr = samp_dr(tag, s); e.di = ~e.dr; e.chn = pc[7:0];
            e.sync = (s == 0); e.last = (s == last_s);
            exp_q.push_back(e);
         end
         if (stop) break;
      end
   endtask

   task automatic send_pkt(input int nbeats, input int eop_beat, input logic [3:0] filt,
                           input logic [15:0] pc, input logic [3:0] tag);
      logic [127:0] d;
      logic [15:0]  dr;
      bit           got;
      int           w;
      model_pkt(nbeats, eop_beat, filt, pc, tag);
      for (int b = 0; b < nbeats; b++) begin
         for (int k = 0; k < 4; k++) begin
            dr = samp_dr(tag, 4 * b + k);
            d[32*k +: 32] = {~dr, dr};
         end
         avst_sink_u_data = d;
         avst_sink_u_valid = 1'b1;
         avst_sink_u_startofpacket = (b == 0);
         avst_sink_u_endofpacket = (b + 1 == eop_beat);
         rx_u_filterIndex = filt;
         rx_u_pc_id = pc;
         w = 0;
         do begin
            @(negedge clk_dsp);
            got = avst_sink_u_ready;
            @(posedge clk_dsp);
            #1;
            w++;
         end while (!got && w < 100);
         if (!got) begin
            tests++; fails++;
            $display("FAIL beat_accept_timeout: beat %0d not accepted, expected acceptance within 100 cycles", b + 1);
            break;
         end
         if (b == 0) begin sop_cyc = cyc; acc_first = cyc; end
         acc_last = cyc;
      end
      avst_sink_u_valid = 1'b0;
      avst_sink_u_startofpacket = 1'b0;
      avst_sink_u_endofpacket = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk_dsp);
      #1;
   endtask

   // Per-cycle comparison of the output stream against the model queue.
   always @(negedge clk_dsp) begin
      if (!rst_dsp) begin
         if (err) n_err++;
         if (dout_dv) begin
            n_samp++;
            if (sync_out) sync_cyc = cyc;
            if (dout_last) begin
               n_last++; last_idx = int'(dout_dr[11:0]); last_chn = dout_chn;
            end
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL sample_extra: got dr=%h di=%h, expected no sample", dout_dr, dout_di);
            end else begin
               e_cur = exp_q.pop_front();
               if (dout_dr !== e_cur.dr || dout_di !== e_cur.di || dout_chn !== e_cur.chn ||
                   sync_out !== e_cur.sync || dout_last !== e_cur.last) begin
                  fails++;
                  $display("FAIL sample: got dr=%h di=%h chn=%h sync=%b last=%b, expected dr=%h di=%h chn=%h sync=%b last=%b",
                           dout_dr, dout_di, dout_chn, sync_out, dout_last,
                           e_cur.dr, e_cur.di, e_cur.chn, e_cur.sync, e_cur.last);
               end
            end
            if (sync_out) in_pkt = 1;
            if (dout_last) in_pkt = 0;
         end else begin
            if (in_pkt) n_gap++;
            tests++;
            if (sync_out || dout_last) begin
               fails++;
               $display("FAIL flags_without_dv: got sync=%b last=%b, expected 0 0", sync_out, dout_last);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int exp_pkt;
      begin_scn();
      // Reset state
      repeat (3) @(posedge clk_dsp);
      @(negedge clk_dsp);
      check("reset_ready", int'(avst_sink_u_ready), 0);
      check("reset_dv", int'(dout_dv), 0);
      check("reset_err", int'(err), 0);
      check("reset_pkt_cnt", int'(pkt_cnt), 0);
      @(posedge clk_dsp); #1;
      rst_dsp = 1'b0;
      @(negedge clk_dsp);
      check("ready_before_rise", int'(avst_sink_u_ready), 0);
      @(negedge clk_dsp);
      check("ready_after_reset", int'(avst_sink_u_ready), 1);
      @(posedge clk_dsp); #1;

      // Full good packet with source valid every cycle
      begin_scn();
      send_pkt(NB, NB, 4'd1, 16'h0005, 4'h1);
      idle(30);
      check("good_samples", n_samp, 839);
      check("good_last_idx", last_idx, 838);
      check("good_last_count", n_last, 1);
      check("good_chn", int'(dout_chn), 5);
      check("good_sync_latency", sync_cyc - sop_cyc, 2);
      check("good_err", n_err, 0);
      check("good_dv_gaps", n_gap, 0);
      check("good_throttle", int'((acc_last - acc_first) >= 832 && (acc_last - acc_first) <= 840), 1);
      check("good_queue_drained", exp_q.size(), 0);

      // Rejected filterIndex
      begin_scn();
      send_pkt(NB, NB, 4'd2, 16'h0007, 4'h2);
      idle(30);
      check("badfilt_err", n_err, 1);
      check("badfilt_err_model", n_err, exp_err);
      check("badfilt_samples", n_samp, 0);

      // Early EOP on beat 100, then an intact packet
      begin_scn();
      send_pkt(100, 100, 4'd1, 16'h0009, 4'h3);
      idle(30);
      check("short_err", n_err, 1);
      check("short_samples", n_samp, 400);
      check("short_last_idx", last_idx, 399);
      check("short_queue_drained", exp_q.size(), 0);
      begin_scn();
      send_pkt(NB, NB, 4'd1, 16'h1234, 4'h4);
      idle(30);
      check("after_short_samples", n_samp, 839);
      check("after_short_chn", int'(last_chn), 8'h34);
      check("after_short_err", n_err, 0);
      check("after_short_drained", exp_q.size(), 0);

      // Missing EOP on beat 210, EOP on beat 212
      begin_scn();
      send_pkt(212, 212, 4'd1, 16'h00AB, 4'h5);
      idle(30);
      check("long_err", n_err, 1);
      check("long_err_model", n_err, exp_err);
      check("long_samples", n_samp, 839);
      check("long_last_idx", last_idx, 838);
      check("long_queue_drained", exp_q.size(), 0);

      // Reset after beat 50 abandons the packet silently
      begin_scn();
      send_pkt(50, 0, 4'd1, 16'h0011, 4'h6);
      rst_dsp = 1'b1;
      exp_q.delete();
      @(posedge clk_dsp);
      @(negedge clk_dsp);
      check("midrst_dv", int'(dout_dv), 0);
      check("midrst_dr", int'(dout_dr), 0);
      check("midrst_chn", int'(dout_chn), 0);
      check("midrst_ready", int'(avst_sink_u_ready), 0);
      check("midrst_err_out", int'(err), 0);
      @(posedge clk_dsp); #1;
      rst_dsp = 1'b0;
      n_samp = 0;
      idle(20);
      check("midrst_no_dv_after", n_samp, 0);
      check("midrst_no_err", n_err, 0);
      begin_scn();
      send_pkt(NB, NB, 4'd1, 16'h0022, 4'h7);
      idle(30);
      check("post_rst_samples", n_samp, 839);
      check("post_rst_last_idx", last_idx, 838);
      check("post_rst_err", n_err, 0);
      check("post_rst_drained", exp_q.size(), 0);
`ifdef PRACH_DEFRAMER_STATS_EN
      exp_pkt = 1;
`else
      exp_pkt = 0;
`endif
      check("pkt_cnt", int'(pkt_cnt), exp_pkt);
      check("err_cnt", int'(err_cnt), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
